// File: rtl/rotary_seq_pkg.sv
// Shared state encoding, valve patterns and mux path decode for the
// two-mux / rotary-mixer valve sequencer.
package rotary_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        G1,
        MIX,
        G2,
        FLUSH,
        G3,
        AGUARD
    } seq_state_e;

    localparam int MIX_STEPS = 6;

    // Peristaltic wave on e3,e4,e2; e1 (inlet) and e5 (outlet) stay closed.
    localparam logic [4:0] MIX_PATTERN [MIX_STEPS] = '{
        5'h06, 5'h04, 5'h0C, 5'h08, 5'h0A, 5'h02
    };

    localparam logic [4:0] FILL_E  = 5'h0F;
    localparam logic [4:0] FLUSH_E = 5'h1F;

    // Binary-tree mux: each select bit opens exactly one of its level's pair.
    function automatic logic [7:0] mux_path(input logic [3:0] sel);
        logic [7:0] path;
        for (int n = 0; n < 4; n++) begin
            path[2*n]   = ~sel[n];
            path[2*n+1] = sel[n];
        end
        return path;
    endfunction

endpackage

// File: rtl/peristaltic_pattern_gen.sv
// Step/rotation sequencer for the mixer's peristaltic wave. e_mix is the
// pattern for the coming cycle so the parent can register it directly.
module peristaltic_pattern_gen
    import rotary_seq_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ROT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic [LEN_W-1:0] step_len,
    input  logic [ROT_W-1:0] rotations,
    output logic [4:0]       e_mix,
    output logic             last
);

    localparam logic [2:0] LAST_STEP = 3'(MIX_STEPS - 1);

    logic [2:0]       idx_q, idx_d;
    logic [LEN_W-1:0] hold_q, hold_d, hold_load;
    logic [ROT_W-1:0] rot_q, rot_d;
    logic             step_end;

    assign hold_load = (step_len == '0) ? '0 : step_len - 1'b1;
    assign step_end  = (hold_q == '0);

    // Final hold cycle of the final step of the final rotation.
    assign last = run && step_end && (idx_q == LAST_STEP) &&
                  ((ROT_W+1)'(rot_q) + (ROT_W+1)'(1) == (ROT_W+1)'(rotations));

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        idx_d  = idx_q;
        hold_d = hold_q;
        rot_d  = rot_q;
        if (start) begin
            idx_d  = '0;
            hold_d = hold_load;
            rot_d  = '0;
        end else if (run) begin
            if (step_end) begin
                hold_d = hold_load;
                if (idx_q == LAST_STEP) begin
                    idx_d = '0;
                    rot_d = rot_q + 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                hold_d = hold_q - 1'b1;
            end
        end
    end

    assign e_mix = MIX_PATTERN[idx_d];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            idx_q  <= '0;
            hold_q <= '0;
            rot_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            rot_q  <= rot_d;
        end
    end

endmodule

// File: rtl/rotary_mix_sequencer.sv
// Fill / mix / flush valve sequencer with break-before-make guard intervals
// and abort handling; all valve outputs come straight from flops.
module rotary_mix_sequencer
    import rotary_seq_pkg::*;
#(
    parameter int LEN_W        = 8,
    parameter int ROT_W        = 8,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_src,
    input  logic [3:0]       cmd_dst,
    input  logic [LEN_W-1:0] cmd_fill_len,
    input  logic [LEN_W-1:0] cmd_step_len,
    input  logic [ROT_W-1:0] cmd_rotations,
    input  logic [LEN_W-1:0] cmd_flush_len,
    input  logic             abort,
    output logic [7:0]       c_a,
    output logic [7:0]       c_b,
    output logic [4:0]       e,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [LEN_W-1:0] GUARD_M1 = LEN_W'(GUARD_CYCLES - 1);

    function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] timer_q, timer_d;
    logic [3:0]       src_q, dst_q;
    logic [LEN_W-1:0] step_q, flush_q;
    logic [ROT_W-1:0] rot_q;
    logic [7:0]       c_a_q, c_a_d, c_b_q, c_b_d;
    logic [4:0]       e_q, e_d, e_mix;
    logic             done_q, done_d, aborted_q, aborted_d;
    logic             accept, phase_end, mix_start, mix_last;

    assign cmd_ready = (state_q == IDLE) && !abort && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (timer_q == '0);

    peristaltic_pattern_gen #(
        .LEN_W (LEN_W),
        .ROT_W (ROT_W)
    ) u_pattern (
        .clk       (clk),
        .rst       (rst),
        .start     (mix_start),
        .run       (state_q == MIX),
        .step_len  (step_q),
        .rotations (rot_q),
        .e_mix     (e_mix),
        .last      (mix_last)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = phase_end ? timer_q : timer_q - 1'b1;
        mix_start = 1'b0;
        if (abort && state_q != IDLE && state_q != AGUARD) begin
            state_d = AGUARD;
            timer_d = GUARD_M1;
        end else begin
            unique case (state_q)
                IDLE:   if (accept) begin
                            state_d = FILL;
                            timer_d = len_m1(cmd_fill_len);
                        end
                FILL:   if (phase_end) begin
                            state_d = G1;
                            timer_d = GUARD_M1;
                        end
                G1:     if (phase_end) begin
                            if (rot_q == '0) begin
                                state_d = G2;
                                timer_d = GUARD_M1;
                            end else begin
                                state_d   = MIX;
                                mix_start = 1'b1;
                            end
                        end
                MIX:    if (mix_last) begin
                            state_d = G2;
                            timer_d = GUARD_M1;
                        end
                G2:     if (phase_end) begin
                            state_d = FLUSH;
                            timer_d = len_m1(flush_q);
                        end
                FLUSH:  if (phase_end) begin
                            state_d = G3;
                            timer_d = GUARD_M1;
                        end
                G3:     if (phase_end) state_d = IDLE;
                AGUARD: if (phase_end) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the flops show the new phase
    // in its first cycle; the source is bypassed on the accept cycle.
    always_comb begin
        c_a_d     = '0;
        c_b_d     = '0;
        e_d       = '0;
        done_d    = (state_q == G3) && (state_d == IDLE);
        aborted_d = (state_q == AGUARD) && (state_d == IDLE);
        unique case (state_d)
            FILL: begin
                c_a_d = mux_path(accept ? cmd_src : src_q);
                e_d   = FILL_E;
            end
            MIX:  e_d = e_mix;
            FLUSH: begin
                c_a_d = mux_path(src_q);
                c_b_d = mux_path(dst_q);
                e_d   = FLUSH_E;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            step_q    <= '0;
            rot_q     <= '0;
            flush_q   <= '0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            e_q       <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            c_a_q     <= c_a_d;
            c_b_q     <= c_b_d;
            e_q       <= e_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (accept) begin
                src_q   <= cmd_src;
                dst_q   <= cmd_dst;
                step_q  <= cmd_step_len;
                rot_q   <= cmd_rotations;
                flush_q <= cmd_flush_len;
            end
        end
    end

    assign c_a     = c_a_q;
    assign c_b     = c_b_q;
    assign e       = e_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_rotary_mix_sequencer.sv
// Bench for rotary_mix_sequencer: a per-cycle schedule model built from the
// phase rules, checked every cycle, plus hand-computed directed expectations.
module tb_rotary_mix_sequencer;

    localparam int LEN_W = 8;
    localparam int ROT_W = 8;
    localparam int GUARD = 2;
    localparam logic [4:0] PAT [6] = '{5'h06, 5'h04, 5'h0C, 5'h08, 5'h0A, 5'h02};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       cmd_src = '0, cmd_dst = '0;
    logic [LEN_W-1:0] cmd_fill_len = '0, cmd_step_len = '0, cmd_flush_len = '0;
    logic [ROT_W-1:0] cmd_rotations = '0;
    logic             cmd_ready, busy, done, aborted;
    logic [7:0]       c_a, c_b;
    logic [4:0]       e;

    always #5 clk = ~clk;

    rotary_mix_sequencer #(
        .LEN_W (LEN_W), .ROT_W (ROT_W), .GUARD_CYCLES (GUARD)
    ) dut (
        .clk (clk), .rst (rst), .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_src (cmd_src), .cmd_dst (cmd_dst), .cmd_fill_len (cmd_fill_len),
        .cmd_step_len (cmd_step_len), .cmd_rotations (cmd_rotations),
        .cmd_flush_len (cmd_flush_len), .abort (abort), .c_a (c_a), .c_b (c_b),
        .e (e), .busy (busy), .done (done), .aborted (aborted)
    );

    typedef struct packed {
        logic [7:0] ca;
        logic [7:0] cb;
        logic [4:0] ev;
        logic       busy;
        logic       done;
        logic       aborted;
        logic       ag;
        logic       fl;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    bit   live = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] path(input logic [3:0] s);
        logic [7:0] p = '0;
        for (int n = 0; n < 4; n++) p[2*n + int'(s[n])] = 1'b1;
        return p;
    endfunction

    function automatic int span(input int len);
        return (len < 1) ? 1 : len;
    endfunction

    task automatic push_n(input exp_t x, input int n);
        for (int i = 0; i < n; i++) q.push_back(x);
    endtask

    // Whole transaction laid out cycle by cycle from the phase rules.
    task automatic schedule(input logic [3:0] src, input logic [3:0] dst, input int fill,
                            input int step, input int rot, input int flush);
        exp_t x;
        exp_t g = '0;
        g.busy = 1'b1;
        x = g; x.ca = path(src); x.ev = 5'h0F;
        push_n(x, span(fill));
        push_n(g, GUARD);
        for (int r = 0; r < rot; r++)
            for (int s = 0; s < 6; s++) begin
                x = g; x.ev = PAT[s];
                push_n(x, span(step));
            end
        push_n(g, GUARD);
        x = g; x.fl = 1'b1; x.ca = path(src); x.cb = path(dst); x.ev = 5'h1F;
        push_n(x, span(flush));
        push_n(g, GUARD);
        x = '0; x.done = 1'b1;
        q.push_back(x);
    endtask

    task automatic model_step(output exp_t nxt);
        exp_t x;
        nxt = '0;
        if (rst) begin
            q.delete();
        end else if (cur.busy && !cur.ag && abort) begin
            q.delete();
            x = '0; x.busy = 1'b1; x.ag = 1'b1;
            push_n(x, GUARD);
            x = '0; x.aborted = 1'b1;
            q.push_back(x);
            nxt = q.pop_front();
        end else begin
            if (!cur.busy && cmd_valid && !abort)
                schedule(cmd_src, cmd_dst, int'(cmd_fill_len), int'(cmd_step_len),
                         int'(cmd_rotations), int'(cmd_flush_len));
            if (q.size() > 0) nxt = q.pop_front();
        end
    endtask

    always @(posedge clk) begin : model
        exp_t nxt;
        model_step(nxt);
        cur  <= nxt;
        live <= 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            check("c_a", c_a, cur.ca);
            check("c_b", c_b, cur.cb);
            check("e", e, cur.ev);
            check("busy", busy, cur.busy);
            check("done", done, cur.done);
            check("aborted", aborted, cur.aborted);
            check("cmd_ready", cmd_ready, !cur.busy && !abort && !rst);
            check("pop_a", ($countones(c_a) == 0) || ($countones(c_a) == 4), 1);
            check("pop_b", ($countones(c_b) == 0) || ($countones(c_b) == 4), 1);
            if (!cur.fl) begin
                check("cb_outside_flush", c_b, 0);
                check("e1_e5_outside_flush", e[0] & e[4], 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input int src, input int dst, input int fill,
                             input int step, input int rot, input int flush);
        cmd_src       = 4'(src);
        cmd_dst       = 4'(dst);
        cmd_fill_len  = LEN_W'(fill);
        cmd_step_len  = LEN_W'(step);
        cmd_rotations = ROT_W'(rot);
        cmd_flush_len = LEN_W'(flush);
        cmd_valid     = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check("idle_reached", busy, 0);
    endtask

    initial begin
        // Reset with a command offered.
        drive_cmd(7, 2, 3, 1, 1, 1);
        repeat (3) tick();
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ca", c_a, 0);
        check("rst_e", e, 0);
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);
        tick();

        // A: full transaction, accepted at T.
        drive_cmd(5, 10, 4, 2, 1, 3);
        tick();
        cmd_valid = 1'b0;
        check("A_fill_ca", c_a, 8'h66);
        check("A_fill_e", e, 5'h0F);
        for (int k = 2; k <= 26; k++) begin
            tick();
            case (k)
                4:  check("A_fill_last_ca", c_a, 8'h66);
                5:  check("A_g1_ca", c_a, 0);
                7:  check("A_mix0", e, 5'h06);
                9:  check("A_mix1", e, 5'h04);
                18: check("A_mix5", e, 5'h02);
                19: check("A_g2_e", e, 0);
                21: begin
                    check("A_flush_ca", c_a, 8'h66);
                    check("A_flush_cb", c_b, 8'h99);
                    check("A_flush_e", e, 5'h1F);
                end
                24: check("A_g3_cb", c_b, 0);
                25: check("A_pre_done", done, 0);
                26: begin
                    check("A_done", done, 1);
                    check("A_idle", busy, 0);
                end
                default: ;
            endcase
        end
        tick();

        // B: minimal lengths, no mix; C queued back-to-back in B's done cycle.
        drive_cmd(0, 15, 0, 5, 0, 0);
        tick();
        cmd_valid = 1'b0;
        check("B_fill_ca", c_a, 8'h55);
        for (int k = 2; k <= 9; k++) begin
            tick();
            case (k)
                2: check("B_fill_one_cycle", c_a, 0);
                6: begin
                    check("B_flush_cb", c_b, 8'hAA);
                    check("B_flush_ca", c_a, 8'h55);
                end
                7: check("B_flush_one_cycle", c_b, 0);
                8: begin
                    drive_cmd(3, 12, 2, 1, 2, 2);
                    check("B_g3_not_ready", cmd_ready, 0);
                end
                9: begin
                    check("B_done", done, 1);
                    check("B_done_ready", cmd_ready, 1);
                end
                default: ;
            endcase
        end

        // C: accepted in B's done cycle, aborted in its third MIX cycle.
        tick();
        cmd_valid = 1'b0;
        check("C_fill_busy", busy, 1);
        check("C_fill_ca", c_a, 8'h5A);
        for (int k = 2; k <= 10; k++) begin
            tick();
            case (k)
                5: check("C_mix0", e, 5'h06);
                6: check("C_mix1", e, 5'h04);
                7: begin
                    check("C_mix2", e, 5'h0C);
                    abort = 1'b1;
                end
                8: begin
                    check("C_aguard_e", e, 0);
                    check("C_aguard_busy", busy, 1);
                end
                9: begin
                    abort = 1'b0;
                    check("C_aguard2_e", e, 0);
                end
                10: begin
                    check("C_aborted", aborted, 1);
                    check("C_no_done", done, 0);
                    check("C_idle", busy, 0);
                end
                default: ;
            endcase
        end

        // Abort and valid together in IDLE: blocked, then D accepted.
        tick();
        abort = 1'b1;
        drive_cmd(15, 0, 1, 3, 1, 1);
        #1;
        check("idle_abort_ready", cmd_ready, 0);
        tick();
        check("idle_abort_busy", busy, 0);
        check("idle_abort_ca", c_a, 0);
        tick();
        check("idle_abort_busy2", busy, 0);
        abort = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("D_fill_busy", busy, 1);
        check("D_fill_ca", c_a, 8'hAA);
        wait_idle(200);
        check("D_done", done, 1);

        // E: accepted in D's done cycle, aborted during G1, abort held into IDLE.
        drive_cmd(9, 6, 1, 1, 3, 1);
        tick();
        cmd_valid = 1'b0;
        check("E_fill_ca", c_a, 8'h96);
        tick();
        check("E_g1_ca", c_a, 0);
        abort = 1'b1;
        tick();
        check("E_aguard_busy", busy, 1);
        tick();
        tick();
        check("E_aborted", aborted, 1);
        check("E_ready_blocked", cmd_ready, 0);
        abort = 1'b0;

        // F: reset in the middle of MIX.
        tick();
        drive_cmd(12, 3, 2, 2, 2, 2);
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();
        check("F_mix2", e, 5'h0C);
        rst = 1'b1;
        tick();
        check("F_rst_busy", busy, 0);
        check("F_rst_e", e, 0);
        check("F_rst_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("F_ready_after_rst", cmd_ready, 1);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rotary_mix_sequencer.md
Name: rotary_mix_sequencer

Overview:
- Clocked valve-control sequencer for the two-mux / rotary-mixer device.
- Drives the pneumatic control lines of source MUX16 A (c1..c8), destination MUX16 B (d1..d8) and the rotary mixer (e1..e5).
- Runs one complete transaction per command: fill from a chosen source inlet, peristaltic mix for N rotations, flush to a chosen destination outlet.
- Sits directly upstream of the device netlist; its outputs feed the solenoid drivers.

Parameters:
- LEN_W, 8, width of the fill, step and flush duration fields (cycles).
- ROT_W, 8, width of the rotation count.
- GUARD_CYCLES, 2, length of the all-closed break-before-make interval between phases (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid & ready
- cmd_src  in  4  source inlet index 0..15, selects i1..i16
- cmd_dst  in  4  destination index 0..15, selects k1..k16
- cmd_fill_len  in  LEN_W  FILL duration
- cmd_step_len  in  LEN_W  hold cycles per peristaltic step
- cmd_rotations  in  ROT_W  mix rotations
- cmd_flush_len  in  LEN_W  FLUSH duration
- abort  in  1  abandon the current transaction
- c_a  out  8  mux A controls, bit0=c1 … bit7=c8; 1 = channel open
- c_b  out  8  mux B controls, same mapping as c_a
- e  out  5  mixer controls, bit0=e1 (inlet) … bit4=e5 (outlet)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on completion of an abort

Behaviour:
- All outputs are registered. Reset, or reset asserted mid-transaction, gives at the next edge: c_a=c_b=0, e=0, busy=0, done=0, aborted=0, state=IDLE, and all counters cleared.
- cmd_ready = (state==IDLE) & !abort. Accept = cmd_valid & cmd_ready. All command fields are latched on accept.
- Path decode path(s), 8 bits: for level n=0..3, bit(2n) is set when s[n]=0 and bit(2n+1) is set when s[n]=1. Exactly four bits are set. Examples: path(0)=0x55, path(5)=0x66, path(10)=0x99, path(15)=0xAA.
- State sequence: IDLE → FILL → G1 → MIX → G2 → FLUSH → G3 → IDLE.
- Duration rule: a length field L holds its phase for max(L,1) cycles.
- The first FILL cycle is the cycle after accept.
- FILL: c_a=path(src), c_b=0, e=0x0F (e1..e4 open, e5 closed).
- G1, G2, G3: all outputs 0, each for GUARD_CYCLES cycles.
- MIX: c_a=c_b=0. e follows a 6-step pattern (e3,e4,e2 = 101,100,110,010,011,001), i.e. e = 0x06, 0x04, 0x0C, 0x08, 0x0A, 0x02.
  - Each step is held max(step_len,1) cycles.
  - The step index wraps 5→0 and increments the rotation counter; MIX ends after `rotations` full cycles.
  - rotations=0: MIX is skipped and G1 goes straight to G2.
- FLUSH: c_a=path(src), c_b=path(dst), e=0x1F.
- The cycle that returns to IDLE asserts done=1 and cmd_ready (if abort=0). A back-to-back command may be accepted in that same cycle.
- Abort:
  - abort sampled high in any non-IDLE state, including a guard state: the next cycle enters AGUARD with all outputs 0 for GUARD_CYCLES, then IDLE with aborted=1 and done=0.
  - abort in IDLE is ignored apart from blocking cmd_ready.
  - abort during AGUARD has no further effect.
- Counters never wrap silently. Phase counters are LEN_W bits and load L-1. The rotation counter is ROT_W bits and compares against the latched count.
- Invariant: mux A and mux B paths are never open together except in FLUSH. e1 and e5 are never both open outside FLUSH.

Decomposition:
- Package rotary_seq_pkg contains:
  - the state enum: IDLE, FILL, G1, MIX, G2, FLUSH, G3, AGUARD;
  - the 6-entry mix pattern constant;
  - the phase e-vector constants FILL_E=0x0F and FLUSH_E=0x1F;
  - function mux_path(sel) → 8 bits.
- One sub-module: peristaltic_pattern_gen.
  - Inputs: start, step_len, rotations.
  - Outputs: e_mix[4:0], last.
  - Holds the step-hold counter, the step index and the rotation counter.
  - The top module keeps the FSM and phase timers.

Test Plan:
- Reset with cmd_valid=1 → outputs 0 and cmd_ready=0 during rst. After release, cmd_ready=1.
- src=5, dst=10, fill=4, step=2, rot=1, flush=3, GUARD=2, accepted at cycle T →
  - FILL: c_a=0x66, e=0x0F for T+1..T+4.
  - MIX: e steps through 06,04,0C,08,0A,02 two cycles each, T+7..T+18.
  - FLUSH: c_a=0x66, c_b=0x99, e=0x1F for T+21..T+23.
  - done=1 at T+26.
- src=0, dst=15, rot=0, fill=0, flush=0 → FILL lasts 1 cycle (c_a=0x55), no MIX, FLUSH lasts 1 cycle (c_b=0xAA), done at T+9.
- Abort at the third MIX cycle → next cycle all outputs 0 for 2 cycles, then aborted=1, done=0, busy=0.
- abort=1 and cmd_valid=1 together in IDLE → not accepted, outputs stay 0. A second command with cmd_valid held in the done cycle → accepted, FILL starts the following cycle.
- Assertion across all runs: popcount(c_a) ∈ {0,4}, popcount(c_b) ∈ {0,4}, c_b≠0 only in FLUSH, and e[0]&e[4] only in FLUSH.
